// File: rtl/fpu_pkg.sv
// Shared FPU definitions: opcodes, special operand values, response flag layout,
// the queued request record and the issue controller states.
package fpu_pkg;

   typedef enum logic [2:0] {
      OP_ADD  = 3'd0,
      OP_SUB  = 3'd1,
      OP_MUL  = 3'd2,
      OP_DIV  = 3'd3,
      OP_SQRT = 3'd4,
      OP_CMP  = 3'd5,
      OP_ABS  = 3'd6,
      OP_NEG  = 3'd7
   } fpu_op_e;

   localparam logic [31:0] FP_CANON_NAN = 32'h7FC0_0000;
   localparam logic [31:0] FP_ONE       = 32'h3F80_0000;

   // rsp_flags = {timeout, div0, invalid}
   localparam int FLAG_INVALID = 0;
   localparam int FLAG_DIV0    = 1;
   localparam int FLAG_TIMEOUT = 2;

   typedef struct packed {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  tag;
   } fpu_req_t;

   localparam int REQ_W = $bits(fpu_req_t);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } issue_state_e;

endpackage

// File: rtl/fpu_req_fifo.sv
// Request FIFO with wrapping pointers and an occupancy count; the head entry is
// presented combinationally and stays put until popped.
module fpu_req_fifo #(
   parameter int WIDTH = 71,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wr_data,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rd_data = mem_q[rd_ptr_q];

   always_comb begin
      do_push  = push && !full;
      do_pop   = pop && !empty;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the read side is qualified by empty.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// FPU issue controller: queues CPU requests, issues them one at a time to the FPU
// and returns result, flags and tag, aborting with a canonical NaN on timeout.
//
// state | meaning
// IDLE  | no operation outstanding, waiting for a queued request and a free FPU
// ISSUE | one-cycle fpu_start pulse for the queue head
// WAIT  | counting cycles until fpu_result_valid or TIMEOUT
// RESP  | response held on rsp_* until rsp_ready
module fpu_issue_ctrl
   import fpu_pkg::*;
#(
   parameter int QDEPTH  = 4,
   parameter int TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   input  logic [3:0]  req_tag,
   output logic        fpu_start,
   output logic [2:0]  fpu_op,
   output logic [31:0] fpu_a,
   output logic [31:0] fpu_b,
   input  logic [31:0] fpu_result,
   input  logic        fpu_result_valid,
   input  logic        fpu_busy,
   input  logic        fpu_invalid_op,
   input  logic        fpu_divide_by_zero,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic [3:0]  rsp_tag,
   output logic [2:0]  rsp_flags
);
   localparam int CW = $clog2(QDEPTH) + 1;

   fpu_req_t      push_req, head;
   logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [CW-1:0] fifo_count;

   issue_state_e  state_q, state_d;
   logic [7:0]    wait_cnt_q, wait_cnt_d;
   logic          fpu_start_q, fpu_start_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic [31:0]   rsp_data_q, rsp_data_d;
   logic [3:0]    rsp_tag_q, rsp_tag_d;
   logic [2:0]    rsp_flags_q, rsp_flags_d;

   assign push_req  = {req_op, req_a, req_b, req_tag};
   assign req_ready = !fifo_full;
   assign fifo_push = req_valid && req_ready;

   fpu_req_fifo #(
      .WIDTH (REQ_W),
      .DEPTH (QDEPTH)
   ) u_req_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (fifo_push),
      .pop     (fifo_pop),
      .wr_data (push_req),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign fpu_op = fifo_empty ? 3'd0  : head.op;
   assign fpu_a  = fifo_empty ? 32'd0 : head.a;
   assign fpu_b  = fifo_empty ? 32'd0 : head.b;

   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      rsp_data_d  = rsp_data_q;
      rsp_tag_d   = rsp_tag_q;
      rsp_flags_d = rsp_flags_q;
      fifo_pop    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if ((fifo_count != '0) && !fpu_busy) state_d = ST_ISSUE;
         end
         ST_ISSUE: begin
            state_d    = ST_WAIT;
            wait_cnt_d = '0;
         end
         ST_WAIT: begin
            // A result arriving on the timeout cycle still wins.
            if (fpu_result_valid) begin
               rsp_data_d              = fpu_result;
               rsp_flags_d             = '0;
               rsp_flags_d[FLAG_DIV0]  = fpu_divide_by_zero;
               rsp_flags_d[FLAG_INVALID] = fpu_invalid_op;
               rsp_tag_d               = head.tag;
               fifo_pop                = 1'b1;
               state_d                 = ST_RESP;
            end else if (wait_cnt_q == 8'(TIMEOUT - 1)) begin
               rsp_data_d              = FP_CANON_NAN;
               rsp_flags_d             = '0;
               rsp_flags_d[FLAG_TIMEOUT] = 1'b1;
               rsp_tag_d               = head.tag;
               fifo_pop                = 1'b1;
               state_d                 = ST_RESP;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         ST_RESP: begin
            if (rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      fpu_start_d = (state_d == ST_ISSUE);
      rsp_valid_d = (state_d == ST_RESP);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         wait_cnt_q  <= '0;
         fpu_start_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_tag_q   <= '0;
         rsp_flags_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         fpu_start_q <= fpu_start_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_tag_q   <= rsp_tag_d;
         rsp_flags_q <= rsp_flags_d;
      end
   end

   assign fpu_start = fpu_start_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_tag   = rsp_tag_q;
   assign rsp_flags = rsp_flags_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl: a queue/phase model checked every cycle, a simple FPU
// responder, and directed scenarios with hand-computed expectations.
module tb_fpu_issue_ctrl;
   import fpu_pkg::*;

   localparam int QDEPTH  = 4;
   localparam int TIMEOUT = 15;
   localparam int P_IDLE = 0, P_ISSUE = 1, P_WAIT = 2, P_RESP = 3;

   logic        clk, rst;
   logic        req_valid, req_ready;
   logic [2:0]  req_op;
   logic [31:0] req_a, req_b;
   logic [3:0]  req_tag;
   logic        fpu_start;
   logic [2:0]  fpu_op;
   logic [31:0] fpu_a, fpu_b, fpu_result;
   logic        fpu_result_valid, fpu_busy, fpu_invalid_op, fpu_divide_by_zero;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_data;
   logic [3:0]  rsp_tag;
   logic [2:0]  rsp_flags;

   fpu_issue_ctrl #(.QDEPTH(QDEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
      .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
      .fpu_result(fpu_result), .fpu_result_valid(fpu_result_valid), .fpu_busy(fpu_busy),
      .fpu_invalid_op(fpu_invalid_op), .fpu_divide_by_zero(fpu_divide_by_zero),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_flags(rsp_flags)
   );

   typedef struct { logic [2:0] op; logic [31:0] a; logic [31:0] b; logic [3:0] tag; } req_t;
   typedef struct { logic [31:0] data; logic [3:0] tag; logic [2:0] flags; int cyc; } rsp_t;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // model state
   req_t        mq[$];
   int          ph;
   int          wait_edges;
   logic [31:0] m_data;
   logic [3:0]  m_tag;
   logic [2:0]  m_flags;
   bit          m_take;
   req_t        m_new;

   // monitor logs
   int   starts[$];
   rsp_t rsp_log[$];
   rsp_t mon_r;
   int   last_acc;
   bit   saw_full;

   // FPU responder controls
   bit          fpu_respond = 1'b1;
   bit          spurious    = 1'b0;
   int          fpu_cnt;
   logic [2:0]  l_op;
   logic [31:0] l_a, l_b, e_res;
   logic        e_dz, e_inv;

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   function automatic void fpu_eval(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic dz, output logic inv);
      dz = 1'b0; inv = 1'b0;
      case (op)
         OP_ADD:  r = (a == FP_ONE && b == FP_ONE) ? 32'h4000_0000 : a + b;
         OP_DIV:  if (b == 32'd0) begin r = 32'h7F80_0000; dz = 1'b1; end else r = a ^ b;
         OP_SQRT: if (a[31]) begin r = FP_CANON_NAN; inv = 1'b1; end else r = a;
         default: r = a ^ b;
      endcase
   endfunction

   initial begin clk = 1'b0; forever #5 clk = ~clk; end
   initial forever begin @(posedge clk); cyc++; end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // Reference model: queue of pending requests plus which of the four phases the
   // controller must be in; updated on each edge from the inputs seen at that edge.
   initial begin
      ph = P_IDLE; wait_edges = 0; m_data = '0; m_tag = '0; m_flags = '0;
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            mq.delete(); ph = P_IDLE; wait_edges = 0;
            m_data = '0; m_tag = '0; m_flags = '0;
         end else begin
            m_take = req_valid && (mq.size() < QDEPTH);
            m_new  = '{req_op, req_a, req_b, req_tag};
            case (ph)
               P_IDLE:  if (mq.size() != 0 && !fpu_busy) ph = P_ISSUE;
               P_ISSUE: begin ph = P_WAIT; wait_edges = 0; end
               P_WAIT: begin
                  if (fpu_result_valid) begin
                     m_data = fpu_result; m_flags = {1'b0, fpu_divide_by_zero, fpu_invalid_op};
                     m_tag = mq[0].tag; void'(mq.pop_front()); ph = P_RESP;
                  end else begin
                     wait_edges++;
                     if (wait_edges == TIMEOUT) begin
                        m_data = FP_CANON_NAN; m_flags = 3'b100;
                        m_tag = mq[0].tag; void'(mq.pop_front()); ph = P_RESP;
                     end
                  end
               end
               default: if (rsp_ready) ph = P_IDLE;
            endcase
            if (m_take) mq.push_back(m_new);
         end
      end
   end

   // per-cycle comparison against the model
   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         check("req_ready", 32'(req_ready), 32'(mq.size() < QDEPTH));
         check("fpu_start", 32'(fpu_start), 32'(ph == P_ISSUE));
         if (mq.size() != 0) begin
            check("fpu_op", 32'(fpu_op), 32'(mq[0].op));
            check("fpu_a", fpu_a, mq[0].a);
            check("fpu_b", fpu_b, mq[0].b);
         end else begin
            check("fpu_op_empty", 32'(fpu_op), 32'd0);
            check("fpu_a_empty", fpu_a, 32'd0);
            check("fpu_b_empty", fpu_b, 32'd0);
         end
         check("rsp_valid", 32'(rsp_valid), 32'(ph == P_RESP));
         check("rsp_data", rsp_data, m_data);
         check("rsp_tag", 32'(rsp_tag), 32'(m_tag));
         check("rsp_flags", 32'(rsp_flags), 32'(m_flags));
      end
   end

   // event monitor; cycle k is the period that ends at edge k
   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (fpu_start) starts.push_back(cyc + 1);
            if (req_valid && req_ready) last_acc = cyc + 1;
            if (!req_ready) saw_full = 1'b1;
            if (rsp_valid && rsp_ready) begin
               mon_r.data = rsp_data; mon_r.tag = rsp_tag; mon_r.flags = rsp_flags; mon_r.cyc = cyc + 1;
               rsp_log.push_back(mon_r);
            end
         end
      end
   end

   // FPU responder: result_valid two cycles after the start pulse
   initial begin
      fpu_result_valid = 1'b0; fpu_result = '0; fpu_invalid_op = 1'b0; fpu_divide_by_zero = 1'b0;
      fpu_cnt = 0;
      forever begin
         @(negedge clk);
         fpu_result_valid = 1'b0; fpu_result = '0; fpu_invalid_op = 1'b0; fpu_divide_by_zero = 1'b0;
         if (rst) fpu_cnt = 0;
         else if (fpu_cnt != 0) begin
            fpu_cnt--;
            if (fpu_cnt == 0) begin
               fpu_eval(l_op, l_a, l_b, e_res, e_dz, e_inv);
               fpu_result_valid = 1'b1; fpu_result = e_res;
               fpu_divide_by_zero = e_dz; fpu_invalid_op = e_inv;
            end
         end else if (spurious) begin
            spurious = 1'b0; fpu_result_valid = 1'b1; fpu_result = 32'hDEAD_BEEF;
            fpu_divide_by_zero = 1'b1;
         end
         if (!rst && fpu_start && fpu_respond) begin
            l_op = fpu_op; l_a = fpu_a; l_b = fpu_b; fpu_cnt = 2;
         end
      end
   end

   task automatic sync();
      @(posedge clk); #1;
   endtask

   task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
      bit acc;
      acc = 1'b0;
      req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
      for (int i = 0; i < 100 && !acc; i++) begin
         @(negedge clk); acc = req_ready;
         sync();
      end
      req_valid = 1'b0;
      check("send_accept", 32'(acc), 32'd1);
   endtask

   task automatic wait_idle(input string nm);
      int k;
      k = 0;
      @(negedge clk);
      while ((mq.size() != 0 || ph != P_IDLE) && k < 400) begin @(negedge clk); k++; end
      check(nm, 32'(k < 400), 32'd1);
      sync();
   endtask

   task automatic wait_starts(input int n);
      int k;
      k = 0;
      while (starts.size() < n && k < 100) begin @(negedge clk); k++; end
      check("wait_start", 32'(k < 100), 32'd1);
      sync();
   endtask

   task automatic clear_logs();
      starts.delete(); rsp_log.delete(); saw_full = 1'b0;
   endtask

   int n0, bad, k;
   logic [31:0] hd; logic [3:0] ht; logic [2:0] hf;

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; req_tag = '0;
      rsp_ready = 1'b1; fpu_busy = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_fpu_start", 32'(fpu_start), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_data", rsp_data, 32'd0);
      sync(); rst = 1'b0;
      sync();

      // ADD 1.0 + 1.0, latency from acceptance
      clear_logs();
      send(OP_ADD, FP_ONE, FP_ONE, 4'd5);
      wait_idle("add_idle");
      check("add_nrsp", rsp_log.size(), 32'd1);
      check("add_nstart", starts.size(), 32'd1);
      check("add_start_cyc", starts[0], last_acc + 2);
      check("add_rsp_cyc", rsp_log[0].cyc, last_acc + 5);
      check("add_data", rsp_log[0].data, 32'h4000_0000);
      check("add_tag", 32'(rsp_log[0].tag), 32'd5);
      check("add_flags", 32'(rsp_log[0].flags), 32'd0);

      // DIV by zero, then SQRT of a negative number
      clear_logs();
      send(OP_DIV, FP_ONE, 32'd0, 4'd2);
      wait_idle("div_idle");
      send(OP_SQRT, 32'hBF80_0000, 32'd0, 4'd7);
      wait_idle("sqrt_idle");
      check("div_data", rsp_log[0].data, 32'h7F80_0000);
      check("div_flags", 32'(rsp_log[0].flags), 32'b010);
      check("div_tag", 32'(rsp_log[0].tag), 32'd2);
      check("sqrt_data", rsp_log[1].data, 32'h7FC0_0000);
      check("sqrt_flags", 32'(rsp_log[1].flags), 32'b001);
      check("sqrt_tag", 32'(rsp_log[1].tag), 32'd7);

      // five back-to-back requests into a four-deep queue
      clear_logs();
      for (int t = 0; t < 5; t++) send(OP_MUL, 32'h1000_0000 + t, 32'h0000_00F0, 4'(t));
      wait_idle("b2b_idle");
      check("b2b_full_seen", 32'(saw_full), 32'd1);
      check("b2b_nrsp", rsp_log.size(), 32'd5);
      check("b2b_nstart", starts.size(), 32'd5);
      for (int t = 0; t < 5; t++) begin
         check("b2b_tag", 32'(rsp_log[t].tag), t);
         check("b2b_data", rsp_log[t].data, 32'h1000_00F0 + t);
      end

      // timeout on an unresponsive FPU, then the next request issues normally
      clear_logs();
      fpu_respond = 1'b0;
      send(OP_ADD, FP_ONE, FP_ONE, 4'd9);
      wait_starts(1);
      fpu_respond = 1'b1;
      send(OP_SUB, 32'd5, 32'd3, 4'd10);
      wait_idle("to_idle");
      check("to_nrsp", rsp_log.size(), 32'd2);
      check("to_data", rsp_log[0].data, 32'h7FC0_0000);
      check("to_flags", 32'(rsp_log[0].flags), 32'b100);
      check("to_tag", 32'(rsp_log[0].tag), 32'd9);
      check("to_rsp_cyc", rsp_log[0].cyc, starts[0] + 16);
      check("to_next_start", starts[1], rsp_log[0].cyc + 2);
      check("to_next_data", rsp_log[1].data, 32'd6);
      check("to_next_tag", 32'(rsp_log[1].tag), 32'd10);

      // response back-pressure for 10 cycles
      clear_logs();
      rsp_ready = 1'b0;
      send(OP_ADD, 32'd1, 32'd2, 4'd3);
      send(OP_MUL, 32'd9, 32'd8, 4'd4);
      k = 0;
      @(negedge clk);
      while (!rsp_valid && k < 50) begin @(negedge clk); k++; end
      check("bp_rsp_seen", 32'(k < 50), 32'd1);
      hd = rsp_data; ht = rsp_tag; hf = rsp_flags; n0 = starts.size(); bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (!rsp_valid || rsp_data !== hd || rsp_tag !== ht || rsp_flags !== hf) bad++;
      end
      check("bp_held_data", hd, 32'd3);
      check("bp_held_tag", 32'(ht), 32'd3);
      check("bp_stable", bad, 32'd0);
      check("bp_no_start", starts.size(), n0);
      sync(); rsp_ready = 1'b1;
      wait_idle("bp_idle");
      check("bp_nrsp", rsp_log.size(), 32'd2);
      check("bp_order", 32'(rsp_log[1].tag), 32'd4);

      // result_valid outside WAIT must be ignored
      clear_logs();
      spurious = 1'b1;
      repeat (4) sync();
      check("spur_nrsp", rsp_log.size(), 32'd0);
      check("spur_rsp_valid", 32'(rsp_valid), 32'd0);

      // busy FPU holds off issue
      clear_logs();
      fpu_busy = 1'b1;
      send(OP_MUL, 32'd7, 32'd1, 4'd6);
      repeat (5) sync();
      check("busy_no_start", starts.size(), 32'd0);
      fpu_busy = 1'b0;
      wait_idle("busy_idle");
      check("busy_nstart", starts.size(), 32'd1);
      check("busy_tag", 32'(rsp_log[0].tag), 32'd6);

      // reset while waiting drops everything
      clear_logs();
      fpu_respond = 1'b0;
      send(OP_ADD, FP_ONE, FP_ONE, 4'd11);
      send(OP_SUB, 32'd4, 32'd1, 4'd12);
      wait_starts(1);
      repeat (3) sync();
      rst = 1'b1;
      @(negedge clk);
      check("mrst_req_ready", 32'(req_ready), 32'd1);
      check("mrst_fpu_start", 32'(fpu_start), 32'd0);
      check("mrst_fpu_op", 32'(fpu_op), 32'd0);
      check("mrst_fpu_a", fpu_a, 32'd0);
      check("mrst_fpu_b", fpu_b, 32'd0);
      check("mrst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("mrst_rsp_data", rsp_data, 32'd0);
      check("mrst_rsp_tag", 32'(rsp_tag), 32'd0);
      check("mrst_rsp_flags", 32'(rsp_flags), 32'd0);
      sync(); rst = 1'b0;
      clear_logs();
      fpu_respond = 1'b1;
      repeat (30) sync();
      check("mrst_no_rsp", rsp_log.size(), 32'd0);
      check("mrst_no_start", starts.size(), 32'd0);

      // normal operation after reset
      send(OP_ADD, FP_ONE, FP_ONE, 4'd1);
      wait_idle("post_idle");
      check("post_data", rsp_log[0].data, 32'h4000_0000);
      check("post_tag", 32'(rsp_log[0].tag), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
